fpu_addsub_unit: RTL and testbench



---
 rtl/fpu_defs.sv | 33 +++
 rtl/fpu_unpack.sv | 26 ++
 rtl/fpu_addsub_unit.sv | 210 +++++++++++++++++++++
 tb/tb_fpu_addsub_unit.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/fpu_defs.sv
// Shared encodings and constants for the coprocessor-1 add/sub stage.
package fpu_defs;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int NORM_MAX_DEF = 24;

    localparam logic [31:0] QNAN_WORD = 32'h7FC0_0000;
    localparam logic [31:0] INF_WORD  = 32'h7F80_0000;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_MOV = 3'b010,
        OP_NEG = 3'b011,
        OP_ABS = 3'b100
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_UNPACK = 3'd1,
        ST_ADD    = 3'd2,
        ST_NORM   = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    function automatic logic [31:0] fp_pack(input logic sign,
                                            input logic [EXP_W-1:0] expo,
                                            input logic [MAN_W-1:0] frac);
        return {sign, expo, frac};
    endfunction

endpackage

// File: rtl/fpu_unpack.sv
// Splits a single-precision word into fields and classifies it; denormals read as zero.
module fpu_unpack
    import fpu_defs::*;
(
    input  logic [31:0]      word,
    output logic             sign,
    output logic [EXP_W-1:0] expo,
    output logic [MAN_W:0]   mant,
    output logic             is_zero,
    output logic             is_inf,
    output logic             is_nan
);

    logic [MAN_W-1:0] frac;

    always_comb begin
        sign    = word[31];
        expo    = word[30:23];
        frac    = word[22:0];
        is_zero = (expo == '0);
        is_inf  = (expo == '1) && (frac == '0);
        is_nan  = (expo == '1) && (frac != '0);
        mant    = is_zero ? '0 : {1'b1, frac};
    end

endmodule

// File: rtl/fpu_addsub_unit.sv
// Multicycle single-precision ADD/SUB/MOV/NEG/ABS stage with register-bank write-back.
//   state  | meaning
//   IDLE   | waiting for iStart; fast ops finish straight from here
//   UNPACK | special-case resolution, operand swap and alignment
//   ADD    | mantissa add or subtract, carry handling and overflow
//   NORM   | one left shift per cycle until the hidden bit is set
//   DONE   | one-cycle write-back strobe
module fpu_addsub_unit
    import fpu_defs::*;
#(
    parameter int          NORM_MAX = NORM_MAX_DEF,
    parameter logic [31:0] QNAN     = QNAN_WORD
)
(
    input  logic        iCLK,
    input  logic        iCLR,
    input  logic        iStart,
    input  logic [2:0]  iOp,
    input  logic [31:0] iA,
    input  logic [31:0] iB,
    input  logic [4:0]  iDestReg,
    output logic        oBusy,
    output logic        oDone,
    output logic        oRegWrite,
    output logic [4:0]  oWriteRegister,
    output logic [31:0] oResult,
    output logic        oOverflow
);

    localparam int CNT_W = $clog2(NORM_MAX + 1);

    state_e           state;
    logic [31:0]      a_q, b_q;
    logic             res_sign, sub_r;
    logic [EXP_W-1:0] exp_r;
    logic [MAN_W:0]   ma_r, mb_r;
    logic [CNT_W-1:0] norm_cnt;

    logic             a_s, b_s, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [EXP_W-1:0] a_e, b_e;
    logic [MAN_W:0]   a_m, b_m;

    fpu_unpack u_unpack_a (
        .word(a_q), .sign(a_s), .expo(a_e), .mant(a_m),
        .is_zero(a_zero), .is_inf(a_inf), .is_nan(a_nan)
    );

    fpu_unpack u_unpack_b (
        .word(b_q), .sign(b_s), .expo(b_e), .mant(b_m),
        .is_zero(b_zero), .is_inf(b_inf), .is_nan(b_nan)
    );

    logic             spec_hit;
    logic [31:0]      spec_res;
    logic             a_big, s_big;
    logic [EXP_W-1:0] e_big, e_small, e_diff;
    logic [MAN_W:0]   m_big, m_small, m_shift;
    logic [MAN_W+1:0] m_sum;
    logic [MAN_W:0]   m_dif;
    logic [31:0]      fast_res;

    always_comb begin
        spec_hit = 1'b1;
        spec_res = '0;
        if (a_nan || b_nan)
            spec_res = QNAN;
        else if (a_inf && b_inf)
            spec_res = (a_s == b_s) ? a_q : QNAN;
        else if (a_inf)
            spec_res = a_q;
        else if (b_inf)
            spec_res = b_q;
        else if (a_zero && b_zero)
            spec_res = {a_s & b_s, 31'd0};
        else if (a_zero)
            spec_res = b_q;
        else if (b_zero)
            spec_res = a_q;
        else
            spec_hit = 1'b0;
    end

    // Magnitude order follows directly from the biased exponent:fraction bits.
    always_comb begin
        a_big   = (a_q[30:0] >= b_q[30:0]);
        s_big   = a_big ? a_s : b_s;
        e_big   = a_big ? a_e : b_e;
        e_small = a_big ? b_e : a_e;
        m_big   = a_big ? a_m : b_m;
        m_small = a_big ? b_m : a_m;
        e_diff  = e_big - e_small;
        m_shift = (e_diff >= 8'd24) ? '0 : (m_small >> e_diff);
    end

    always_comb begin
        m_sum = {1'b0, ma_r} + {1'b0, mb_r};
        m_dif = ma_r - mb_r;
    end

    always_comb begin
        case (iOp)
            OP_NEG:  fast_res = {~iA[31], iA[30:0]};
            OP_ABS:  fast_res = {1'b0, iA[30:0]};
            default: fast_res = iA;
        endcase
    end

    always_ff @(posedge iCLK or posedge iCLR) begin
        if (iCLR) begin
            state          <= ST_IDLE;
            oBusy          <= 1'b0;
            oDone          <= 1'b0;
            oRegWrite      <= 1'b0;
            oOverflow      <= 1'b0;
            oResult        <= '0;
            oWriteRegister <= '0;
            a_q            <= '0;
            b_q            <= '0;
            res_sign       <= 1'b0;
            sub_r          <= 1'b0;
            exp_r          <= '0;
            ma_r           <= '0;
            mb_r           <= '0;
            norm_cnt       <= '0;
        end else begin
            oDone     <= 1'b0;
            oRegWrite <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (iStart) begin
                        oBusy          <= 1'b1;
                        oOverflow      <= 1'b0;
                        oWriteRegister <= iDestReg;
                        a_q            <= iA;
                        b_q            <= (iOp == OP_SUB) ? {~iB[31], iB[30:0]} : iB;
                        if (iOp == OP_ADD || iOp == OP_SUB) begin
                            state <= ST_UNPACK;
                        end else begin
                            oResult   <= fast_res;
                            oDone     <= 1'b1;
                            oRegWrite <= 1'b1;
                            state     <= ST_DONE;
                        end
                    end
                end
                ST_UNPACK: begin
                    if (spec_hit) begin
                        oResult   <= spec_res;
                        oDone     <= 1'b1;
                        oRegWrite <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        exp_r    <= e_big;
                        ma_r     <= m_big;
                        mb_r     <= m_shift;
                        res_sign <= s_big;
                        sub_r    <= a_s ^ b_s;
                        state    <= ST_ADD;
                    end
                end
                ST_ADD: begin
                    norm_cnt <= CNT_W'(NORM_MAX);
                    state    <= ST_NORM;
                    if (sub_r) begin
                        ma_r <= m_dif;
                    end else if (m_sum[MAN_W+1]) begin
                        if (exp_r == 8'd254) begin
                            oResult   <= {res_sign, INF_WORD[30:0]};
                            oOverflow <= 1'b1;
                            oDone     <= 1'b1;
                            oRegWrite <= 1'b1;
                            state     <= ST_DONE;
                        end else begin
                            ma_r  <= m_sum[MAN_W+1:1];
                            exp_r <= exp_r + 8'd1;
                        end
                    end else begin
                        ma_r <= m_sum[MAN_W:0];
                    end
                end
                ST_NORM: begin
                    if (ma_r == '0 || (!ma_r[MAN_W] && (exp_r == 8'd1 || norm_cnt == '0))) begin
                        oResult   <= '0;
                        oDone     <= 1'b1;
                        oRegWrite <= 1'b1;
                        state     <= ST_DONE;
                    end else if (ma_r[MAN_W]) begin
                        oResult   <= fp_pack(res_sign, exp_r, ma_r[MAN_W-1:0]);
                        oDone     <= 1'b1;
                        oRegWrite <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        ma_r     <= {ma_r[MAN_W-1:0], 1'b0};
                        exp_r    <= exp_r - 8'd1;
                        norm_cnt <= norm_cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    oBusy <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    oBusy <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_addsub_unit.sv
// Scoreboard bench for fpu_addsub_unit: expected write-backs queued at issue, checked on oDone.
module tb_fpu_addsub_unit;

    logic        iCLK = 1'b0;
    logic        iCLR;
    logic        iStart;
    logic [2:0]  iOp;
    logic [31:0] iA, iB;
    logic [4:0]  iDestReg;
    logic        oBusy, oDone, oRegWrite, oOverflow;
    logic [4:0]  oWriteRegister;
    logic [31:0] oResult;

    always #5 iCLK = ~iCLK;

    fpu_addsub_unit dut (
        .iCLK(iCLK), .iCLR(iCLR), .iStart(iStart), .iOp(iOp), .iA(iA), .iB(iB),
        .iDestReg(iDestReg), .oBusy(oBusy), .oDone(oDone), .oRegWrite(oRegWrite),
        .oWriteRegister(oWriteRegister), .oResult(oResult), .oOverflow(oOverflow)
    );

    typedef struct {
        logic [31:0] res;
        logic [4:0]  dest;
        logic        ovf;
        int          lat;
        int          start;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    always @(posedge iCLK) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    initial forever begin
        @(posedge iCLK);
        #1;
        if (oDone === 1'b1) begin
            if (sb.size() == 0) begin
                check_val("spurious_done", 32'(oDone), 32'd0);
            end else begin
                cur = sb.pop_front();
                check_val("result", oResult, cur.res);
                check_val("dest", 32'(oWriteRegister), 32'(cur.dest));
                check_val("overflow", 32'(oOverflow), 32'(cur.ovf));
                check_val("latency", 32'(cyc - cur.start), 32'(cur.lat));
                check_val("regwrite", 32'(oRegWrite), 32'd1);
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] dest, input logic [31:0] res, input logic ovf,
                         input int lat);
        exp_t e;
        @(negedge iCLK);
        iStart = 1'b1; iOp = op; iA = a; iB = b; iDestReg = dest;
        e.res = res; e.dest = dest; e.ovf = ovf; e.lat = lat; e.start = cyc;
        sb.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge iCLK);
            n++;
        end
        if (sb.size() != 0) begin
            check_val("timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] dest, input logic [31:0] res, input logic ovf,
                         input int lat);
        issue(op, a, b, dest, res, ovf, lat);
        @(negedge iCLK);
        iStart = 1'b0;
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=%0d want=0", sb.size());
        $fatal(1, "simulation time limit");
    end

    initial begin
        iCLR = 1'b1; iStart = 1'b0; iOp = 3'd0; iA = '0; iB = '0; iDestReg = '0;
        repeat (2) @(negedge iCLK);
        check_val("rst_busy", 32'(oBusy), 32'd0);
        check_val("rst_done", 32'(oDone), 32'd0);
        check_val("rst_regwrite", 32'(oRegWrite), 32'd0);
        check_val("rst_overflow", 32'(oOverflow), 32'd0);
        check_val("rst_result", oResult, 32'd0);
        check_val("rst_dest", 32'(oWriteRegister), 32'd0);
        iCLR = 1'b0;

        // 1.0 + 2.0 with busy profile
        issue(3'd0, 32'h3F80_0000, 32'h4000_0000, 5'd5, 32'h4040_0000, 1'b0, 4);
        for (int c = 1; c <= 5; c++) begin
            @(negedge iCLK);
            if (c == 1) iStart = 1'b0;
            check_val($sformatf("busy_c%0d", c), 32'(oBusy), (c <= 4) ? 32'd1 : 32'd0);
        end
        drain();

        do_op(3'd1, 32'h3FC0_0000, 32'h3FA0_0000, 5'd1, 32'h3E80_0000, 1'b0, 6);
        do_op(3'd1, 32'h4120_0000, 32'h4120_0000, 5'd2, 32'h0000_0000, 1'b0, 4);
        do_op(3'd3, 32'h3F80_0000, 32'h0,         5'd3, 32'hBF80_0000, 1'b0, 1);
        do_op(3'd4, 32'hC000_0000, 32'h0,         5'd4, 32'h4000_0000, 1'b0, 1);
        do_op(3'd2, 32'h1234_5678, 32'hFFFF_FFFF, 5'd6, 32'h1234_5678, 1'b0, 1);
        do_op(3'd7, 32'h8765_4321, 32'h0,         5'd7, 32'h8765_4321, 1'b0, 1);
        do_op(3'd0, 32'h7F80_0000, 32'hFF80_0000, 5'd8, 32'h7FC0_0000, 1'b0, 2);
        do_op(3'd0, 32'h7FC0_0001, 32'h3F80_0000, 5'd9, 32'h7FC0_0000, 1'b0, 2);
        do_op(3'd0, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 5'd10, 32'h7F80_0000, 1'b1, 3);
        do_op(3'd0, 32'h3F80_0000, 32'h3F80_0000, 5'd11, 32'h4000_0000, 1'b0, 4);
        do_op(3'd0, 32'h3F80_0000, 32'hC000_0000, 5'd12, 32'hBF80_0000, 1'b0, 5);
        do_op(3'd0, 32'h8000_0000, 32'h8000_0000, 5'd13, 32'h8000_0000, 1'b0, 2);
        do_op(3'd0, 32'h0000_0000, 32'h8000_0000, 5'd14, 32'h0000_0000, 1'b0, 2);
        do_op(3'd1, 32'h0000_0000, 32'h3F80_0000, 5'd15, 32'hBF80_0000, 1'b0, 2);
        do_op(3'd0, 32'h0000_0001, 32'h3F80_0000, 5'd16, 32'h3F80_0000, 1'b0, 2);
        do_op(3'd0, 32'h7F80_0000, 32'h3F80_0000, 5'd17, 32'h7F80_0000, 1'b0, 2);
        do_op(3'd0, 32'h3F80_0000, 32'h3380_0000, 5'd18, 32'h3F80_0000, 1'b0, 4);
        do_op(3'd0, 32'h3F80_0000, 32'h3400_0000, 5'd19, 32'h3F80_0001, 1'b0, 4);
        do_op(3'd1, 32'h0080_0001, 32'h0080_0000, 5'd20, 32'h0000_0000, 1'b0, 4);

        // oResult holds between operations
        do_op(3'd2, 32'hCAFE_F00D, 32'h0, 5'd21, 32'hCAFE_F00D, 1'b0, 1);
        repeat (3) @(negedge iCLK);
        check_val("result_hold", oResult, 32'hCAFE_F00D);

        // iStart while busy is ignored
        issue(3'd0, 32'h3F80_0000, 32'h4000_0000, 5'd22, 32'h4040_0000, 1'b0, 4);
        @(negedge iCLK);
        iOp = 3'd3; iA = 32'h1111_1111; iDestReg = 5'd30;
        repeat (3) @(negedge iCLK);
        iStart = 1'b0;
        drain();
        repeat (6) @(negedge iCLK);

        // reset in cycle 2 of an ADD aborts without write-back
        @(negedge iCLK);
        iStart = 1'b1; iOp = 3'd0; iA = 32'h3F80_0000; iB = 32'h4000_0000; iDestReg = 5'd9;
        @(negedge iCLK);
        iStart = 1'b0;
        @(negedge iCLK);
        iCLR = 1'b1;
        #1;
        check_val("abort_busy", 32'(oBusy), 32'd0);
        check_val("abort_regwrite", 32'(oRegWrite), 32'd0);
        check_val("abort_result", oResult, 32'd0);
        check_val("abort_dest", 32'(oWriteRegister), 32'd0);
        @(negedge iCLK);
        iCLR = 1'b0;
        repeat (6) @(negedge iCLK);
        check_val("abort_idle_busy", 32'(oBusy), 32'd0);

        do_op(3'd0, 32'h3F80_0000, 32'h4000_0000, 5'd23, 32'h4040_0000, 1'b0, 4);
        repeat (4) @(negedge iCLK);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
